// File: rtl/sos_window3x3_stream.sv
// 3x3 sliding-window generator over a row-major ROWS x COLS cell stream.
// Two line buffers supply the previous rows; windows leave through a valid/ready port.
module sos_window3x3_stream #(
  parameter int DATA_W = 35,
  parameter int COLS   = 34,
  parameter int ROWS   = 34,
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic                  aclk,
  input  logic                  arest_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sof,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic [9*DATA_W-1:0]   win_data,
  output logic [RW-1:0]         win_row,
  output logic [CW-1:0]         win_col,
  output logic                  frame_done,
  output logic                  sof_err
);

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [RW-1:0]        row_r;
  logic [CW-1:0]        col_r;
  logic [RW-1:0]        pos_row_s;
  logic [CW-1:0]        pos_col_s;
  logic [RW-1:0]        row_nxt_s;
  logic [CW-1:0]        col_nxt_s;
  logic                 accept_s;
  logic                 complete_s;
  logic                 frame_end_s;
  logic                 sof_misplaced_s;

  logic [DATA_W-1:0]    lb1_r [COLS];
  logic [DATA_W-1:0]    lb2_r [COLS];
  logic [DATA_W-1:0]    lb1_rd_s;
  logic [DATA_W-1:0]    lb2_rd_s;

  logic [DATA_W-1:0]    tap_r     [9];
  logic [DATA_W-1:0]    tap_nxt_s [9];
  logic [9*DATA_W-1:0]  win_pack_s;

  logic                 win_valid_r;
  logic [9*DATA_W-1:0]  win_data_r;
  logic [RW-1:0]        win_row_r;
  logic [CW-1:0]        win_col_r;
  logic                 frame_done_r;
  logic                 sof_err_r;

  // No skid buffer: a held window blocks the input directly.
  assign in_ready   = !win_valid_r || win_ready;
  assign accept_s   = in_valid && in_ready;

  assign win_valid  = win_valid_r;
  assign win_data   = win_data_r;
  assign win_row    = win_row_r;
  assign win_col    = win_col_r;
  assign frame_done = frame_done_r;
  assign sof_err    = sof_err_r;

  // Position of the cell being accepted; SOF forces it to the grid origin.
  always_comb begin
    pos_row_s       = row_r;
    pos_col_s       = col_r;
    sof_misplaced_s = 1'b0;
    if (in_sof) begin
      pos_row_s       = '0;
      pos_col_s       = '0;
      sof_misplaced_s = (row_r != '0) || (col_r != '0);
    end else begin
      pos_row_s       = row_r;
      pos_col_s       = col_r;
      sof_misplaced_s = 1'b0;
    end
  end

  // Row-major advance with wrap at the last column and the last row.
  always_comb begin
    row_nxt_s = pos_row_s;
    col_nxt_s = pos_col_s;
    if (pos_col_s == COL_LAST) begin
      col_nxt_s = '0;
      if (pos_row_s == ROW_LAST) begin
        row_nxt_s = '0;
      end else begin
        row_nxt_s = pos_row_s + RW'(1);
      end
    end else begin
      col_nxt_s = pos_col_s + CW'(1);
      row_nxt_s = pos_row_s;
    end
  end

  assign complete_s  = (pos_row_s >= ROW_TWO) && (pos_col_s >= COL_TWO);
  assign frame_end_s = (pos_row_s == ROW_LAST) && (pos_col_s == COL_LAST);
  assign lb1_rd_s    = lb1_r[pos_col_s];
  assign lb2_rd_s    = lb2_r[pos_col_s];

  // Post-shift tap values; each row shifts tap 3g -> 3g+1 -> 3g+2.
  always_comb begin
    for (int g = 0; g < 3; g++) begin
      tap_nxt_s[3*g+1] = tap_r[3*g];
      tap_nxt_s[3*g+2] = tap_r[3*g+1];
    end
    tap_nxt_s[0] = in_data;
    tap_nxt_s[3] = lb1_rd_s;
    tap_nxt_s[6] = lb2_rd_s;
  end

  // Pack post-shift taps into the output word layout.
  always_comb begin
    win_pack_s = '0;
    for (int k = 0; k < 9; k++) begin
      win_pack_s[k*DATA_W +: DATA_W] = tap_nxt_s[k];
    end
  end

  // Line buffers are never cleared: stale rows cannot reach a window.
  always_ff @(posedge aclk) begin
    if (accept_s) begin
      lb2_r[pos_col_s] <= lb1_rd_s;
      lb1_r[pos_col_s] <= in_data;
    end else begin
      lb2_r[pos_col_s] <= lb2_rd_s;
      lb1_r[pos_col_s] <= lb1_rd_s;
    end
  end

  // Grid position counters and tap shift registers.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      row_r <= '0;
      col_r <= '0;
      for (int k = 0; k < 9; k++) begin
        tap_r[k] <= '0;
      end
    end else if (accept_s) begin
      row_r <= row_nxt_s;
      col_r <= col_nxt_s;
      for (int k = 0; k < 9; k++) begin
        tap_r[k] <= tap_nxt_s[k];
      end
    end else begin
      row_r <= row_r;
      col_r <= col_r;
    end
  end

  // Window output register: load on completion, release on handshake, else hold.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      win_valid_r <= 1'b0;
      win_data_r  <= '0;
      win_row_r   <= '0;
      win_col_r   <= '0;
    end else if (accept_s && complete_s) begin
      win_valid_r <= 1'b1;
      win_data_r  <= win_pack_s;
      win_row_r   <= pos_row_s - RW'(1);
      win_col_r   <= pos_col_s - CW'(1);
    end else if (win_valid_r && win_ready) begin
      win_valid_r <= 1'b0;
    end else begin
      win_valid_r <= win_valid_r;
    end
  end

  // End-of-frame pulse and sticky misplaced-SOF flag.
  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      frame_done_r <= 1'b0;
      sof_err_r    <= 1'b0;
    end else begin
      frame_done_r <= accept_s && frame_end_s;
      if (accept_s && sof_misplaced_s) begin
        sof_err_r <= 1'b1;
      end else begin
        sof_err_r <= sof_err_r;
      end
    end
  end

endmodule

// File: tb/tb_sos_window3x3_stream.sv
// Self-checking bench: grid-array reference model with scoreboard for the default
// instance, plus a table-driven run on a small 5x4 instance.
module tb_sos_window3x3_stream;

  localparam int DW = 35;
  localparam int NC = 34;
  localparam int NR = 34;

  logic          aclk;
  logic          arest_n;
  logic          in_valid, in_ready, in_sof;
  logic [DW-1:0] in_data;
  logic          win_valid, win_ready;
  logic [9*DW-1:0] win_data;
  logic [5:0]    win_row, win_col;
  logic          frame_done, sof_err;

  logic          sm_in_valid, sm_in_ready, sm_in_sof;
  logic [7:0]    sm_in_data;
  logic          sm_win_valid, sm_win_ready;
  logic [71:0]   sm_win_data;
  logic [1:0]    sm_win_row;
  logic [2:0]    sm_win_col;
  logic          sm_frame_done, sm_sof_err;

  sos_window3x3_stream dut (
    .aclk(aclk), .arest_n(arest_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  sos_window3x3_stream #(.DATA_W(8), .COLS(5), .ROWS(4)) dut_small (
    .aclk(aclk), .arest_n(arest_n),
    .in_valid(sm_in_valid), .in_ready(sm_in_ready), .in_sof(sm_in_sof), .in_data(sm_in_data),
    .win_valid(sm_win_valid), .win_ready(sm_win_ready), .win_data(sm_win_data),
    .win_row(sm_win_row), .win_col(sm_win_col),
    .frame_done(sm_frame_done), .sof_err(sm_sof_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9*DW-1:0] data;
    int              row;
    int              col;
  } win_t;

  win_t          exp_q[$];
  logic [DW-1:0] mf [NR][NC];
  int            mr = 0, mc = 0;
  bit            fd_exp = 0, wv_exp = 0, sof_exp = 0, prev_stall = 0;
  win_t          held_w, first_w, last_w;
  int            win_cnt = 0, fd_cnt = 0;
  int            bp_mode = 0;

  task automatic chk(input string nm, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", nm, got, expv, $time);
    end
  endtask

  task automatic chk_data(input string nm, input logic [9*DW-1:0] got, input logic [9*DW-1:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, got, expv, $time);
    end
  endtask

  // Reference model: store each cell at its grid position and read the 3x3 block back.
  task automatic model_accept(input logic [DW-1:0] d, input logic sof);
    win_t w;
    if (sof) begin
      if (mr != 0 || mc != 0) sof_exp = 1'b1;
      mr = 0;
      mc = 0;
    end
    mf[mr][mc] = d;
    wv_exp = (mr >= 2 && mc >= 2);
    fd_exp = (mr == NR-1 && mc == NC-1);
    if (wv_exp) begin
      w.data = '0;
      for (int k = 0; k < 9; k++) w.data[k*DW +: DW] = mf[mr - k/3][mc - k%3];
      w.row = mr - 1;
      w.col = mc - 1;
      exp_q.push_back(w);
    end
    mc++;
    if (mc == NC) begin
      mc = 0;
      mr = (mr == NR-1) ? 0 : mr + 1;
    end
  endtask

  // Monitor: samples on the falling edge, between driver updates and DUT edges.
  initial forever begin
    win_t e;
    @(negedge aclk);
    if (!arest_n) begin
      exp_q.delete();
      mr = 0; mc = 0;
      fd_exp = 0; wv_exp = 0; sof_exp = 0; prev_stall = 0;
    end else begin
      chk("in_ready", longint'(in_ready), longint'(!win_valid || win_ready));
      chk("frame_done", longint'(frame_done), longint'(fd_exp));
      chk("sof_err", longint'(sof_err), longint'(sof_exp));
      if (frame_done) fd_cnt++;
      if (wv_exp) chk("latency_win_valid", longint'(win_valid), 64'd1);
      if (prev_stall) begin
        chk("stall_valid", longint'(win_valid), 64'd1);
        chk_data("stall_data", win_data, held_w.data);
        chk("stall_row", longint'(win_row), longint'(held_w.row));
        chk("stall_col", longint'(win_col), longint'(held_w.col));
      end
      if (win_valid && win_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk_data("win_data", win_data, e.data);
          chk("win_row", longint'(win_row), longint'(e.row));
          chk("win_col", longint'(win_col), longint'(e.col));
        end
        if (win_cnt == 0) begin
          first_w.data = win_data; first_w.row = int'(win_row); first_w.col = int'(win_col);
        end
        last_w.data = win_data; last_w.row = int'(win_row); last_w.col = int'(win_col);
        win_cnt++;
      end
      prev_stall  = win_valid && !win_ready;
      held_w.data = win_data; held_w.row = int'(win_row); held_w.col = int'(win_col);
      if (in_valid && in_ready) begin
        model_accept(in_data, in_sof);
      end else begin
        fd_exp = 0;
        wv_exp = 0;
      end
    end
  end

  // Downstream ready generator.
  initial begin
    win_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (bp_mode)
        0:       win_ready = 1'b1;
        1:       win_ready = ($urandom_range(0, 99) >= 30);
        default: win_ready = 1'b0;
      endcase
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic sof);
    bit acc = 0;
    int budget = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = d;
    while (!acc && budget < 2000) begin
      @(negedge aclk);
      acc = in_ready;
      @(posedge aclk);
      #1;
      budget++;
    end
    if (!acc) chk("send_timeout", 64'd1, 64'd0);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_ramp(input bit gaps);
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) begin
        if (gaps && $urandom_range(0, 9) == 0) begin
          @(posedge aclk);
          #1;
        end
        send(DW'(r*NC + c), (r == 0 && c == 0));
      end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [2:0]  hi = 3'($urandom_range(0, 7));
    logic [31:0] lo = $urandom;
    return {hi, lo};
  endfunction

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge aclk);
      #1;
      n++;
    end
    repeat (3) begin
      @(posedge aclk);
      #1;
    end
    chk("drain_queue_empty", longint'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, longint'(in_ready), 64'd1);
    chk({tag, "_win_valid"}, longint'(win_valid), 64'd0);
    chk_data({tag, "_win_data"}, win_data, '0);
    chk({tag, "_win_row"}, longint'(win_row), 64'd0);
    chk({tag, "_win_col"}, longint'(win_col), 64'd0);
    chk({tag, "_frame_done"}, longint'(frame_done), 64'd0);
    chk({tag, "_sof_err"}, longint'(sof_err), 64'd0);
  endtask

  task automatic check_ramp_frame(input string tag);
    chk({tag, "_count"}, longint'(win_cnt), 64'd1024);
    chk({tag, "_frame_done_count"}, longint'(fd_cnt), 64'd1);
    chk({tag, "_first_row"}, longint'(first_w.row), 64'd1);
    chk({tag, "_first_col"}, longint'(first_w.col), 64'd1);
    chk({tag, "_first_tap0"}, longint'(first_w.data[0 +: DW]), 64'd70);
    chk({tag, "_first_tap4"}, longint'(first_w.data[4*DW +: DW]), 64'd35);
    chk({tag, "_first_tap8"}, longint'(first_w.data[8*DW +: DW]), 64'd0);
    chk({tag, "_last_row"}, longint'(last_w.row), 64'd32);
    chk({tag, "_last_col"}, longint'(last_w.col), 64'd32);
    chk({tag, "_last_tap0"}, longint'(last_w.data[0 +: DW]), 64'd1155);
  endtask

  typedef struct {
    logic       sof;
    logic [7:0] data;
    logic       exp_win;
    logic [1:0] exp_row;
    logic [2:0] exp_col;
    logic [7:0] exp_t0, exp_t4, exp_t8;
    logic       exp_fd;
  } sm_vec_t;

  sm_vec_t sm_tab[20];

  initial begin
    int sm_wins;
    // Small-grid vectors: ramp data r*5+c on a 5-column, 4-row grid.
    for (int i = 0; i < 20; i++) begin
      sm_tab[i].sof     = (i == 0);
      sm_tab[i].data    = 8'(i);
      sm_tab[i].exp_win = (i / 5 >= 2) && (i % 5 >= 2);
      sm_tab[i].exp_row = 2'(i / 5 - 1);
      sm_tab[i].exp_col = 3'(i % 5 - 1);
      sm_tab[i].exp_t0  = 8'(i);
      sm_tab[i].exp_t4  = 8'(i - 6);
      sm_tab[i].exp_t8  = 8'(i - 12);
      sm_tab[i].exp_fd  = (i == 19);
    end

    arest_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    sm_in_valid = 1'b0; sm_in_sof = 1'b0; sm_in_data = '0; sm_win_ready = 1'b1;
    #3;
    check_reset_outputs("reset_initial");
    @(posedge aclk);
    #1;
    arest_n = 1'b1;
    @(posedge aclk);
    #1;

    // Full ramp frame at full throughput.
    win_cnt = 0; fd_cnt = 0;
    send_ramp(1'b0);
    drain();
    check_ramp_frame("ramp");

    // Same frame under random backpressure and input gaps.
    bp_mode = 1;
    win_cnt = 0; fd_cnt = 0;
    send_ramp(1'b1);
    drain();
    bp_mode = 0;
    check_ramp_frame("bp_ramp");

    // Two back-to-back random frames with SOF on each first cell.
    win_cnt = 0; fd_cnt = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NR*NC; i++) send(rnd_data(), (i == 0));
    drain();
    chk("b2b_count", longint'(win_cnt), 64'd2048);
    chk("b2b_frame_done_count", longint'(fd_cnt), 64'd2);
    chk("b2b_sof_err", longint'(sof_err), 64'd0);

    // Misplaced SOF on the 500th cell, followed by a full frame from that cell.
    win_cnt = 0; fd_cnt = 0;
    for (int i = 0; i < 499; i++) send(rnd_data(), (i == 0));
    chk("pre_sof_err", longint'(sof_err), 64'd0);
    send(rnd_data(), 1'b1);
    for (int i = 0; i < NR*NC - 1; i++) send(rnd_data(), 1'b0);
    drain();
    chk("midsof_sof_err", longint'(sof_err), 64'd1);
    chk("midsof_count", longint'(win_cnt), 64'd1429);
    chk("midsof_frame_done_count", longint'(fd_cnt), 64'd1);

    // Stall a window, then reset asynchronously mid-cycle.
    bp_mode = 2;
    @(posedge aclk);
    #1;
    for (int i = 0; i < 2*NC + 3; i++) send(DW'((i / NC) * NC + i % NC), (i == 0));
    repeat (2) begin
      @(posedge aclk);
      #1;
    end
    chk("stall_pending_valid", longint'(win_valid), 64'd1);
    chk("stall_in_ready_low", longint'(in_ready), 64'd0);
    chk("stall_sof_err_kept", longint'(sof_err), 64'd1);
    @(posedge aclk);
    #2;
    arest_n = 1'b0;
    #1;
    check_reset_outputs("reset_midcycle");
    @(posedge aclk);
    #1;
    bp_mode = 0;
    arest_n = 1'b1;
    @(posedge aclk);
    #1;

    // Small grid: table-driven, one cell per cycle.
    sm_wins = 0;
    for (int i = 0; i < 20; i++) begin
      sm_in_valid = 1'b1;
      sm_in_sof   = sm_tab[i].sof;
      sm_in_data  = sm_tab[i].data;
      @(posedge aclk);
      #1;
      chk("sm_win_valid", longint'(sm_win_valid), longint'(sm_tab[i].exp_win));
      chk("sm_frame_done", longint'(sm_frame_done), longint'(sm_tab[i].exp_fd));
      if (sm_tab[i].exp_win) begin
        sm_wins++;
        chk("sm_win_row", longint'(sm_win_row), longint'(sm_tab[i].exp_row));
        chk("sm_win_col", longint'(sm_win_col), longint'(sm_tab[i].exp_col));
        chk("sm_tap0", longint'(sm_win_data[7:0]), longint'(sm_tab[i].exp_t0));
        chk("sm_tap4", longint'(sm_win_data[39:32]), longint'(sm_tab[i].exp_t4));
        chk("sm_tap8", longint'(sm_win_data[71:64]), longint'(sm_tab[i].exp_t8));
      end
    end
    sm_in_valid = 1'b0;
    sm_in_sof   = 1'b0;
    @(posedge aclk);
    #1;
    chk("sm_release_valid", longint'(sm_win_valid), 64'd0);
    chk("sm_window_count", longint'(sm_wins), 64'd6);
    chk("sm_sof_err", longint'(sm_sof_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog timeout got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
